// File: rtl/div_share_ctrl.sv
// Two-client signed-division front end for a shared pipelined unsigned divider chain:
// round-robin issue with per-client credits, a tag pipe tracking the chain, and per-client response FIFOs.
`timescale 1ns/1ps
module div_share_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 32,
    parameter int DEPTH   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num,
    input  logic [WIDTH-1:0] req0_den,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num,
    input  logic [WIDTH-1:0] req1_den,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_quot,
    output logic [WIDTH-1:0] rsp0_rem,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_quot,
    output logic [WIDTH-1:0] rsp1_rem,
    output logic             rsp1_err,
    output logic             div_start,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_m,
    output logic [WIDTH-1:0] div_accu,
    output logic             div_sign_num,
    output logic             div_sign_den,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q_in,
    input  logic [WIDTH-1:0] div_accu_in,
    input  logic             div_sign_num_in,
    input  logic             div_sign_den_in,
    output logic             sync_err
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // valid never waits on ready, ready may look at the other requester's valid, and
    // response data holds steady while valid is high and ready is low.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed { logic valid; logic id; logic div0; } tag_t;
    typedef struct packed { logic [WIDTH-1:0] quot; logic [WIDTH-1:0] rem; logic err; } rsp_t;

    logic [1:0]       req_valid, rsp_ready, credit, can_issue, grant, ready, issue, rsp_valid, pop, push;
    logic [WIDTH-1:0] req_num [2];
    logic [WIDTH-1:0] req_den [2];
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];
    logic             prio_q, prio_d, sel;
    logic [WIDTH-1:0] sel_num, sel_den;
    logic             div_start_q, iss_id_q, iss_div0_q, sign_num_q, sign_den_q;
    logic [WIDTH-1:0] div_q_q, div_m_q;
    tag_t             tag_q [LATENCY];
    tag_t             tag_out;
    rsp_t             ret;
    rsp_t             mem_q [2][DEPTH];
    logic [AW:0]      wptr_q [2];
    logic [AW:0]      rptr_q [2];
    logic             sync_err_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_ready  = {rsp1_ready, rsp0_ready};
    assign req_num[0] = req0_num;
    assign req_num[1] = req1_num;
    assign req_den[0] = req0_den;
    assign req_den[1] = req1_den;

    always_comb begin
        credit    = '0;
        can_issue = '0;
        for (int k = 0; k < 2; k++) begin
            credit[k]    = cnt_q[k] < CW'(DEPTH);
            can_issue[k] = req_valid[k] && credit[k];
        end
        // A requester is locked out only when the other one can issue and holds priority.
        grant[0] = !(can_issue[1] && prio_q);
        grant[1] = !(can_issue[0] && !prio_q);
        ready    = RST ? 2'b00 : (credit & grant);
        issue    = req_valid & ready;
        sel      = issue[1];
        sel_num  = req_num[sel];
        sel_den  = req_den[sel];
        prio_d   = (|issue) ? ~sel : prio_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_start_q <= 1'b0;
            div_q_q     <= '0;
            div_m_q     <= '0;
            sign_num_q  <= 1'b0;
            sign_den_q  <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_div0_q  <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            div_start_q <= |issue;
            prio_q      <= prio_d;
            if (|issue) begin
                div_q_q    <= mag(sel_num);
                div_m_q    <= mag(sel_den);
                sign_num_q <= sel_num[WIDTH-1];
                sign_den_q <= sel_den[WIDTH-1];
                iss_id_q   <= sel;
                iss_div0_q <= (sel_den == '0);
            end
        end
    end

    // Stage 0 is loaded alongside div_start, so the last stage lines up with div_done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {div_start_q, iss_id_q, iss_div0_q};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    always_comb begin
        ret.quot = (div_sign_num_in ^ div_sign_den_in) ? -div_q_in : div_q_in;
        ret.rem  = div_sign_num_in ? -div_accu_in : div_accu_in;
        ret.err  = tag_out.div0;
        // With a zero divisor the chain leaves |num| in ACCU, so rem rebuilds the dividend.
        if (tag_out.div0) ret.quot = '1;
        push              = '0;
        push[tag_out.id]  = tag_out.valid;
    end

    always_comb begin
        rsp_valid = '0;
        for (int k = 0; k < 2; k++) rsp_valid[k] = (wptr_q[k] != rptr_q[k]);
        pop = rsp_valid & rsp_ready;
        for (int k = 0; k < 2; k++) cnt_d[k] = cnt_q[k] + CW'(issue[k]) - CW'(pop[k]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            sync_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wptr_q[k] <= wptr_q[k] + (AW+1)'(1);
                if (pop[k])  rptr_q[k] <= rptr_q[k] + (AW+1)'(1);
                cnt_q[k] <= cnt_d[k];
            end
            if (div_done != tag_out.valid) sync_err_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) mem_q[k][wptr_q[k][AW-1:0]] <= ret;
        end
    end

    assign req0_ready   = ready[0];
    assign req1_ready   = ready[1];
    assign rsp0_valid   = rsp_valid[0];
    assign rsp1_valid   = rsp_valid[1];
    assign {rsp0_quot, rsp0_rem, rsp0_err} = mem_q[0][rptr_q[0][AW-1:0]];
    assign {rsp1_quot, rsp1_rem, rsp1_err} = mem_q[1][rptr_q[1][AW-1:0]];
    assign div_start    = div_start_q;
    assign div_q        = div_q_q;
    assign div_m        = div_m_q;
    assign div_accu     = '0;
    assign div_sign_num = sign_num_q;
    assign div_sign_den = sign_den_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: behavioural divider chain, signed-arithmetic reference model,
// expected/observed response queues and one task per scenario.
`timescale 1ns/1ps
module tb_div_share_ctrl;
  localparam int W = 32;
  localparam int L = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic [W-1:0] req0_num = '0, req0_den = '0, req1_num = '0, req1_den = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [W-1:0] rsp0_quot, rsp0_rem, rsp1_quot, rsp1_rem;
  logic div_start, div_sign_num, div_sign_den, sync_err;
  logic [W-1:0] div_q, div_m, div_accu;
  logic div_done, div_sign_num_in, div_sign_den_in;
  logic [W-1:0] div_q_in, div_accu_in;

  int errors = 0;
  int checks = 0;

  div_share_ctrl #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .CLK(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num(req0_num), .req0_den(req0_den),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num(req1_num), .req1_den(req1_den),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_quot(rsp0_quot), .rsp0_rem(rsp0_rem), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_quot(rsp1_quot), .rsp1_rem(rsp1_rem), .rsp1_err(rsp1_err),
    .div_start(div_start), .div_q(div_q), .div_m(div_m), .div_accu(div_accu),
    .div_sign_num(div_sign_num), .div_sign_den(div_sign_den),
    .div_done(div_done), .div_q_in(div_q_in), .div_accu_in(div_accu_in),
    .div_sign_num_in(div_sign_num_in), .div_sign_den_in(div_sign_den_in),
    .sync_err(sync_err)
  );

  // Divider chain stand-in: never reset, results appear L cycles after Start.
  logic [L-1:0] ch_v = '0;
  logic [W-1:0] ch_q [L];
  logic [W-1:0] ch_r [L];
  logic [L-1:0] ch_sn = '0;
  logic [L-1:0] ch_sd = '0;
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      ch_q[i] <= ch_q[i-1];
      ch_r[i] <= ch_r[i-1];
    end
    ch_v  <= {ch_v[L-2:0], div_start};
    ch_sn <= {ch_sn[L-2:0], div_sign_num};
    ch_sd <= {ch_sd[L-2:0], div_sign_den};
    if (div_m == '0) begin
      ch_q[0] <= '1;
      ch_r[0] <= div_q;
    end else begin
      ch_q[0] <= div_q / div_m;
      ch_r[0] <= div_q % div_m;
    end
  end
  assign div_done        = ch_v[L-1];
  assign div_q_in        = ch_q[L-1];
  assign div_accu_in     = ch_r[L-1];
  assign div_sign_num_in = ch_sn[L-1];
  assign div_sign_den_in = ch_sd[L-1];

  // Reference: {quot, rem, err} from signed arithmetic truncated to W bits.
  function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    longint sn, sd, q, r;
    if (d == '0) return {{W{1'b1}}, n, 1'b1};
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    q = sn / sd;
    r = sn % sd;
    return {q[W-1:0], r[W-1:0], 1'b0};
  endfunction

  logic [2*W:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];
  logic grant_log[$];
  int iss_cnt0 = 0, iss_cnt1 = 0, rsp_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(model(req0_num, req0_den));
        grant_log.push_back(1'b0);
        iss_cnt0++;
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(model(req1_num, req1_den));
        grant_log.push_back(1'b1);
        iss_cnt1++;
      end
      if (rsp0_valid && rsp0_ready) got_q0.push_back({rsp0_quot, rsp0_rem, rsp0_err});
      if (rsp1_valid && rsp1_ready) got_q1.push_back({rsp1_quot, rsp1_rem, rsp1_err});
      if (rsp0_valid || rsp1_valid) rsp_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rand_num();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1, 2: return W'($urandom_range(0, 500));
      3, 4: return '0 - W'($urandom_range(0, 500));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_den();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2, 3: return W'($urandom_range(1, 50));
      4, 5: return '0 - W'($urandom_range(1, 50));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic send(input int k, input logic [W-1:0] n, input logic [W-1:0] d);
    int guard = 0;
    logic hs = 1'b0;
    if (k == 0) begin req0_valid = 1; req0_num = n; req0_den = d; end
    else        begin req1_valid = 1; req1_num = n; req1_den = d; end
    while (!hs && guard < 500) begin
      @(negedge clk);
      hs = (k == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (k == 0) req0_valid = 0; else req1_valid = 0;
    checks++;
    if (!hs) begin errors++; $display("FAIL send_timeout req%0d got no ready within %0d cycles", k, guard); end
  endtask

  task automatic drain_and_score();
    int guard = 0;
    logic [2*W:0] g, e;
    rsp0_ready = 1;
    rsp1_ready = 1;
    while ((got_q0.size() != exp_q0.size() || got_q1.size() != exp_q1.size()) && guard < 1000) begin
      tick(1);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL drain_timeout got0=%0d exp0=%0d got1=%0d exp1=%0d", got_q0.size(), exp_q0.size(), got_q1.size(), exp_q1.size());
    end
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      g = got_q0.pop_front(); e = exp_q0.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rsp0_data got q=%h r=%h e=%b exp q=%h r=%h e=%b", g[2*W:W+1], g[W:1], g[0], e[2*W:W+1], e[W:1], e[0]); end
    end
    while (got_q1.size() > 0 && exp_q1.size() > 0) begin
      g = got_q1.pop_front(); e = exp_q1.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rsp1_data got q=%h r=%h e=%b exp q=%h r=%h e=%b", g[2*W:W+1], g[W:1], g[0], e[2*W:W+1], e[W:1], e[0]); end
    end
    got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic apply_reset();
    rst = 1;
    tick(2);
    rst = 0;
    got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(1);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req1_ready, req0_ready); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b%b exp 00", rsp1_valid, rsp0_valid); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got %b exp 0", div_start); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b exp 0", sync_err); end
    checks++; if (div_q !== '0 || div_m !== '0 || div_accu !== '0) begin errors++; $display("FAIL reset_div_data got q=%h m=%h a=%h exp 0", div_q, div_m, div_accu); end
    rst = 0;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b%b exp 11", req1_ready, req0_ready); end
    tick(1);
  endtask

  task automatic test_basic();
    int n = 1;
    send(0, 32'd100, 32'd7);
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL issue_start got %b exp 1", div_start); end
    checks++; if (div_q !== 32'd100 || div_m !== 32'd7 || div_accu !== '0) begin errors++; $display("FAIL issue_operands got q=%0d m=%0d a=%0d exp 100 7 0", div_q, div_m, div_accu); end
    checks++; if (div_sign_num !== 1'b0 || div_sign_den !== 1'b0) begin errors++; $display("FAIL issue_signs got %b%b exp 00", div_sign_num, div_sign_den); end
    while (!rsp0_valid && n < 200) begin tick(1); n++; end
    checks++; if (n != L + 2) begin errors++; $display("FAIL rsp_latency got %0d exp %0d", n, L + 2); end
    checks++; if (rsp0_quot !== 32'd14 || rsp0_rem !== 32'd2 || rsp0_err !== 1'b0) begin errors++; $display("FAIL basic_result got q=%0d r=%0d e=%b exp 14 2 0", rsp0_quot, rsp0_rem, rsp0_err); end
    drain_and_score();
  endtask

  task automatic test_signs();
    send(1, -32'sd100, 32'd7);
    send(1, 32'd100, -32'sd7);
    send(1, -32'sd100, -32'sd7);
    send(1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if (div_q !== 32'h8000_0000 || div_m !== 32'd1) begin errors++; $display("FAIL min_magnitude got q=%h m=%h exp 80000000 00000001", div_q, div_m); end
    checks++; if (div_sign_num !== 1'b1 || div_sign_den !== 1'b1) begin errors++; $display("FAIL min_signs got %b%b exp 11", div_sign_num, div_sign_den); end
    drain_and_score();
  endtask

  task automatic test_div_zero();
    int guard = 0;
    logic [W-1:0] q_snap;
    rsp0_ready = 0;
    send(0, -32'sd5, 32'd0);
    send(0, 32'd1000, 32'd33);
    while (!rsp0_valid && guard < 200) begin tick(1); guard++; end
    checks++; if (rsp0_quot !== 32'hFFFF_FFFF || rsp0_rem !== 32'hFFFF_FFFB || rsp0_err !== 1'b1) begin errors++; $display("FAIL div0_result got q=%h r=%h e=%b exp ffffffff fffffffb 1", rsp0_quot, rsp0_rem, rsp0_err); end
    q_snap = rsp0_quot;
    tick(3);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_quot !== q_snap || rsp0_err !== 1'b1) begin errors++; $display("FAIL div0_hold got v=%b q=%h e=%b exp 1 %h 1", rsp0_valid, rsp0_quot, rsp0_err, q_snap); end
    drain_and_score();
  endtask

  task automatic test_random();
    int done = 0;
    fork
      begin for (int i = 0; i < 20; i++) send(0, rand_num(), rand_den()); done++; end
      begin for (int i = 0; i < 20; i++) send(1, rand_num(), rand_den()); done++; end
      begin
        while (done < 2) begin
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    drain_and_score();
  endtask

  task automatic test_back_to_back();
    int base, guard = 0;
    logic hs0, hs1;
    apply_reset();
    base = grant_log.size();
    req0_num = rand_num(); req0_den = rand_den(); req0_valid = 1;
    req1_num = rand_num(); req1_den = rand_den(); req1_valid = 1;
    while (grant_log.size() < base + 8 && guard < 300) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      guard++;
      if (hs0) begin req0_num = rand_num(); req0_den = rand_den(); end
      if (hs1) begin req1_num = rand_num(); req1_den = rand_den(); end
    end
    req0_valid = 0;
    req1_valid = 0;
    checks++; if (grant_log.size() < base + 8) begin errors++; $display("FAIL alt_count got %0d exp 8 grants", grant_log.size() - base); end
    for (int i = 0; i < 8 && base + i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[base + i] !== 1'(i % 2)) begin errors++; $display("FAIL alt_order grant %0d got %b exp %0d", i, grant_log[base + i], i % 2); end
    end
    drain_and_score();
  endtask

  task automatic test_credit();
    int b0, b1, guard = 0;
    logic hs0, hs1;
    logic [W-1:0] q_snap, r_snap;
    b0 = iss_cnt0;
    b1 = iss_cnt1;
    rsp0_ready = 0;
    rsp1_ready = 1;
    req0_num = rand_num(); req0_den = rand_den(); req0_valid = 1;
    req1_num = rand_num(); req1_den = rand_den(); req1_valid = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0) begin req0_num = rand_num(); req0_den = rand_den(); end
      if (hs1) begin req1_num = rand_num(); req1_den = rand_den(); end
      if (c == 50) begin q_snap = rsp0_quot; r_snap = rsp0_rem; end
    end
    checks++; if (iss_cnt0 - b0 != D) begin errors++; $display("FAIL credit_issues0 got %0d exp %0d", iss_cnt0 - b0, D); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL credit_ready0 got %b exp 0", req0_ready); end
    checks++; if (iss_cnt1 - b1 <= D) begin errors++; $display("FAIL credit_issues1 got %0d exp more than %0d", iss_cnt1 - b1, D); end
    checks++; if (rsp0_valid !== 1'b1 || rsp0_quot !== q_snap || rsp0_rem !== r_snap) begin errors++; $display("FAIL stall_stable got v=%b q=%h r=%h exp 1 %h %h", rsp0_valid, rsp0_quot, rsp0_rem, q_snap, r_snap); end
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    while (got_q0.size() < exp_q0.size() && guard < 200) begin tick(1); guard++; end
    tick(1);
    checks++; if (got_q0.size() != D) begin errors++; $display("FAIL credit_drain got %0d exp %0d", got_q0.size(), D); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL credit_restore got %b exp 1", req0_ready); end
    drain_and_score();
  endtask

  task automatic test_reset_inflight();
    int seen;
    send(0, 32'd50, 32'd3);
    send(1, -32'sd50, 32'd3);
    send(0, 32'd9, 32'd0);
    send(1, 32'd77, -32'sd4);
    send(0, 32'd1234, 32'd11);
    tick(2);
    rst = 1;
    tick(1);
    rst = 0;
    seen = rsp_seen;
    tick(L + 5);
    checks++; if (rsp_seen != seen) begin errors++; $display("FAIL flush_rsp_valid got %0d cycles exp 0", rsp_seen - seen); end
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_err_set got %b exp 1", sync_err); end
    apply_reset();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_clear got %b exp 0", sync_err); end
    send(1, -32'sd77, 32'd5);
    checks++; if (exp_q1.size() != 1) begin errors++; $display("FAIL fresh_issue got %0d exp 1", exp_q1.size()); end
    drain_and_score();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_fresh got %b exp 0", sync_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_credit();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
